alu_secuenciador: RTL and testbench

- Sequential front-end controller for the shared 4-bit ALU.
- Captures operand A, then operand B plus operation selector, from a single switch bank using a one-button load protocol.
- Presents stable registered operands to the ALU, captures the result, and converts it to BCD with an iterative double-dabble engine.
- Drives the BCD digits of both operands and the result to the 7-segment decoders, replacing combinational divide/modulo logic with a multi-cycle conversion.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/bin_a_bcd_serial.sv | 111 +++++++++++
 rtl/alu_secuenciador.sv | 176 +++++++++++++++++
 tb/tb_alu_secuenciador.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU front-end sequencer: FSM state codes,
// BCD converter constants, the result-width helper and the operand digit
// split used for the 7-segment displays.
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        ESPERA_A  = 3'd0,
        ESPERA_B  = 3'd1,
        EJECUTA   = 3'd2,
        CONVIERTE = 3'd3,
        MUESTRA   = 3'd4
    } estado_t;

    localparam int         BCD_DIGITS  = 3;
    localparam logic [3:0] ADD3_UMBRAL = 4'd5;

    // Result width for a given operand width.
    function automatic int res_w(input int bits);
        return 2 * bits;
    endfunction

    // Splits an operand (0..15) into {tens, units}.
    function automatic logic [7:0] digitos_operando(input logic [3:0] v);
        logic [3:0] dec;
        logic [3:0] uni;
        dec = (v >= 4'd10) ? 4'd1 : 4'd0;
        uni = (v >= 4'd10) ? (v - 4'd10) : v;
        return {dec, uni};
    endfunction

endpackage

// File: rtl/bin_a_bcd_serial.sv
// ---------------------------------------------------------------------------
// bin_a_bcd_serial
// Iterative double-dabble converter: one add-3/shift step per cycle over a
// {bcd[11:0], bin[RES_W-1:0]} shift register, RES_W steps per conversion.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   inicio         load valor and start a conversion
//   valor          binary value to convert (sampled with inicio)
//   abortar        drop any conversion in flight and clear the digits
//   cen, dec, uni  registered BCD digits of the last completed conversion
//   fin            high during the final step; digits update at its edge
// ---------------------------------------------------------------------------
module bin_a_bcd_serial
    import alu_pkg::*;
#(
    parameter int RES_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic [RES_W-1:0] valor,
    input  logic             abortar,
    output logic [3:0]       cen,
    output logic [3:0]       dec,
    output logic [3:0]       uni,
    output logic             fin
);

    localparam int         SR_W   = 4 * BCD_DIGITS + RES_W;
    localparam logic [3:0] ULTIMO = 4'(RES_W - 1);

    logic [SR_W-1:0] sr_q, sr_d, sr_paso, sr_desp;
    logic [3:0]      cnt_q, cnt_d;
    logic            activo_q, activo_d;
    logic [3:0]      cen_q, cen_d, dec_q, dec_d, uni_q, uni_d;

    // One double-dabble step: correct every BCD nibble >= 5, then shift left.
    always_comb begin
        sr_paso = sr_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (sr_q[RES_W + 4*i +: 4] >= ADD3_UMBRAL) begin
                sr_paso[RES_W + 4*i +: 4] = sr_q[RES_W + 4*i +: 4] + 4'd3;
            end else begin
                sr_paso[RES_W + 4*i +: 4] = sr_q[RES_W + 4*i +: 4];
            end
        end
        sr_desp = sr_paso << 1;
    end

    // Conversion control: abort beats start, start beats stepping.
    always_comb begin
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        activo_d = activo_q;
        cen_d    = cen_q;
        dec_d    = dec_q;
        uni_d    = uni_q;
        if (abortar) begin
            sr_d     = '0;
            cnt_d    = 4'd0;
            activo_d = 1'b0;
            cen_d    = 4'd0;
            dec_d    = 4'd0;
            uni_d    = 4'd0;
        end else if (inicio) begin
            sr_d     = {{(4*BCD_DIGITS){1'b0}}, valor};
            cnt_d    = 4'd0;
            activo_d = 1'b1;
        end else if (activo_q) begin
            sr_d = sr_desp;
            if (cnt_q == ULTIMO) begin
                cnt_d    = 4'd0;
                activo_d = 1'b0;
                cen_d    = sr_desp[SR_W-1  -: 4];
                dec_d    = sr_desp[SR_W-5  -: 4];
                uni_d    = sr_desp[SR_W-9  -: 4];
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end else begin
            sr_d = sr_q;
        end
    end

    // Converter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q     <= '0;
            cnt_q    <= 4'd0;
            activo_q <= 1'b0;
            cen_q    <= 4'd0;
            dec_q    <= 4'd0;
            uni_q    <= 4'd0;
        end else begin
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            activo_q <= activo_d;
            cen_q    <= cen_d;
            dec_q    <= dec_d;
            uni_q    <= uni_d;
        end
    end

    // fin is a decode of flops so the FSM can leave CONVIERTE on the same
    // edge that loads the digits.
    assign fin = activo_q && (cnt_q == ULTIMO) && !abortar;
    assign cen = cen_q;
    assign dec = dec_q;
    assign uni = uni_q;

endmodule

// File: rtl/alu_secuenciador.sv
// ---------------------------------------------------------------------------
// alu_secuenciador
// Front-end controller for the shared ALU: loads A, then B and the selector
// from one switch bank via cargar, holds them stable for the ALU, captures
// the result into a serial BCD converter and shows all digits.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   dato, sel_in         switch inputs (operand value, operation selector)
//   cargar, cancelar     single-cycle load / abort pulses (cancelar wins)
//   op_a, op_b, op_sel   registered operands and selector to the ALU
//   alu_salida           combinational ALU result
//   bcd_a_*, bcd_b_*     operand tens/units
//   bcd_r_*              hundreds/tens/units of the last result
//   estado, ocupado, listo  status for LEDs
// ---------------------------------------------------------------------------
module alu_secuenciador
    import alu_pkg::*;
#(
    parameter int Bits = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [Bits-1:0]     dato,
    input  logic [Bits-1:0]     sel_in,
    input  logic                cargar,
    input  logic                cancelar,
    output logic [Bits-1:0]     op_a,
    output logic [Bits-1:0]     op_b,
    output logic [Bits-1:0]     op_sel,
    input  logic [2*Bits-1:0]   alu_salida,
    output logic [3:0]          bcd_a_dec,
    output logic [3:0]          bcd_a_uni,
    output logic [3:0]          bcd_b_dec,
    output logic [3:0]          bcd_b_uni,
    output logic [3:0]          bcd_r_cen,
    output logic [3:0]          bcd_r_dec,
    output logic [3:0]          bcd_r_uni,
    output logic [2:0]          estado,
    output logic                ocupado,
    output logic                listo
);

    localparam int RES_W = res_w(Bits);

    if (Bits < 2 || Bits > 4) begin : g_bits_fuera_de_rango
        $error("alu_secuenciador: Bits must be in 2..4");
    end

    estado_t         state_q, state_d;
    logic [Bits-1:0] op_a_q, op_a_d, op_b_q, op_b_d, op_sel_q, op_sel_d;
    logic [3:0]      a_dec_q, a_dec_d, a_uni_q, a_uni_d;
    logic [3:0]      b_dec_q, b_dec_d, b_uni_q, b_uni_d;
    logic            ocupado_q, ocupado_d, listo_q, listo_d;
    logic            inicio_s, abortar_s, fin_s;
    logic [7:0]      dig_dato_s;

    assign dig_dato_s = digitos_operando(4'(dato));

    // Next-state, operand capture and converter control.
    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_sel_d  = op_sel_q;
        a_dec_d   = a_dec_q;
        a_uni_d   = a_uni_q;
        b_dec_d   = b_dec_q;
        b_uni_d   = b_uni_q;
        inicio_s  = 1'b0;
        abortar_s = 1'b0;
        if (cancelar) begin
            state_d   = ESPERA_A;
            op_a_d    = '0;
            op_b_d    = '0;
            op_sel_d  = '0;
            a_dec_d   = 4'd0;
            a_uni_d   = 4'd0;
            b_dec_d   = 4'd0;
            b_uni_d   = 4'd0;
            abortar_s = 1'b1;
        end else begin
            case (state_q)
                ESPERA_A, MUESTRA: begin
                    if (cargar) begin
                        op_a_d  = dato;
                        a_dec_d = dig_dato_s[7:4];
                        a_uni_d = dig_dato_s[3:0];
                        state_d = ESPERA_B;
                    end else begin
                        state_d = state_q;
                    end
                end
                ESPERA_B: begin
                    if (cargar) begin
                        op_b_d   = dato;
                        op_sel_d = sel_in;
                        b_dec_d  = dig_dato_s[7:4];
                        b_uni_d  = dig_dato_s[3:0];
                        state_d  = EJECUTA;
                    end else begin
                        state_d = state_q;
                    end
                end
                EJECUTA: begin
                    // Operands have been on the ALU for a full cycle here;
                    // the converter captures the result as it starts.
                    inicio_s = 1'b1;
                    state_d  = CONVIERTE;
                end
                CONVIERTE: begin
                    if (fin_s) begin
                        state_d = MUESTRA;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: state_d = ESPERA_A;
            endcase
        end
        ocupado_d = (state_d == EJECUTA) || (state_d == CONVIERTE);
        listo_d   = (state_d == MUESTRA);
    end

    // Sequencer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ESPERA_A;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_sel_q  <= '0;
            a_dec_q   <= 4'd0;
            a_uni_q   <= 4'd0;
            b_dec_q   <= 4'd0;
            b_uni_q   <= 4'd0;
            ocupado_q <= 1'b0;
            listo_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_sel_q  <= op_sel_d;
            a_dec_q   <= a_dec_d;
            a_uni_q   <= a_uni_d;
            b_dec_q   <= b_dec_d;
            b_uni_q   <= b_uni_d;
            ocupado_q <= ocupado_d;
            listo_q   <= listo_d;
        end
    end

    bin_a_bcd_serial #(
        .RES_W (RES_W)
    ) u_bcd (
        .clk     (clk),
        .rst     (rst),
        .inicio  (inicio_s),
        .valor   (alu_salida),
        .abortar (abortar_s),
        .cen     (bcd_r_cen),
        .dec     (bcd_r_dec),
        .uni     (bcd_r_uni),
        .fin     (fin_s)
    );

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_sel    = op_sel_q;
    assign bcd_a_dec = a_dec_q;
    assign bcd_a_uni = a_uni_q;
    assign bcd_b_dec = b_dec_q;
    assign bcd_b_uni = b_uni_q;
    assign estado    = state_q;
    assign ocupado   = ocupado_q;
    assign listo     = listo_q;

endmodule

// File: tb/tb_alu_secuenciador.sv
// ---------------------------------------------------------------------------
// tb_alu_secuenciador
// Self-checking bench: an ALU model (multiply / add / forced value) answers
// the DUT's operands; expected digits come from plain decimal arithmetic.
// ---------------------------------------------------------------------------
module tb_alu_secuenciador;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] dato = 4'd0;
    logic [3:0] sel_in = 4'd0;
    logic       cargar = 1'b0;
    logic       cancelar = 1'b0;
    logic [3:0] op_a, op_b, op_sel;
    logic [7:0] alu_salida;
    logic [3:0] bcd_a_dec, bcd_a_uni, bcd_b_dec, bcd_b_uni;
    logic [3:0] bcd_r_cen, bcd_r_dec, bcd_r_uni;
    logic [2:0] estado;
    logic       ocupado, listo;
    logic [7:0] forced_val = 8'd0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // ALU environment: sel 0 multiplies, sel 1 adds, anything else returns forced_val.
    assign alu_salida = (op_sel == 4'd0) ? ({4'd0, op_a} * {4'd0, op_b}) :
                        (op_sel == 4'd1) ? ({4'd0, op_a} + {4'd0, op_b}) : forced_val;

    alu_secuenciador #(.Bits(4)) dut (
        .clk(clk), .rst(rst), .dato(dato), .sel_in(sel_in),
        .cargar(cargar), .cancelar(cancelar),
        .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .alu_salida(alu_salida),
        .bcd_a_dec(bcd_a_dec), .bcd_a_uni(bcd_a_uni),
        .bcd_b_dec(bcd_b_dec), .bcd_b_uni(bcd_b_uni),
        .bcd_r_cen(bcd_r_cen), .bcd_r_dec(bcd_r_dec), .bcd_r_uni(bcd_r_uni),
        .estado(estado), .ocupado(ocupado), .listo(listo)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_res(input int a, input int b, input int sel, input int forced);
        if (sel == 0) return a * b;
        else if (sel == 1) return a + b;
        else return forced;
    endfunction

    task automatic pulse_load(input logic [3:0] v, input logic [3:0] sel);
        dato   = v;
        sel_in = sel;
        cargar = 1'b1;
        @(negedge clk);
        cargar = 1'b0;
    endtask

    task automatic load_a_check(input int a, input string tag);
        pulse_load(4'(a), 4'd0);
        check_eq({tag, " estado after A"}, estado, 1);
        check_eq({tag, " op_a"}, op_a, a);
        check_eq({tag, " a_dec"}, bcd_a_dec, a / 10);
        check_eq({tag, " a_uni"}, bcd_a_uni, a % 10);
    endtask

    task automatic check_result(input int r, input string tag);
        check_eq({tag, " r_cen"}, bcd_r_cen, r / 100);
        check_eq({tag, " r_dec"}, bcd_r_dec, (r / 10) % 10);
        check_eq({tag, " r_uni"}, bcd_r_uni, r % 10);
    endtask

    // Loads B and selector from ESPERA_B, then times the run to MUESTRA.
    task automatic run_b(input int a, input int b, input int sel, input bit disturb, input string tag);
        int cyc;
        int busy;
        int r;
        pulse_load(4'(b), 4'(sel));
        check_eq({tag, " estado EJECUTA"}, estado, 2);
        check_eq({tag, " op_b"}, op_b, b);
        check_eq({tag, " op_sel"}, op_sel, sel);
        check_eq({tag, " b_dec"}, bcd_b_dec, b / 10);
        check_eq({tag, " b_uni"}, bcd_b_uni, b % 10);
        r = model_res(a, b, sel, int'(forced_val));
        cyc  = 0;
        busy = 0;
        while (!listo && cyc < 20) begin
            if (ocupado) busy++;
            cargar = disturb && (cyc == 0 || cyc == 4);
            dato   = 4'd3;
            @(negedge clk);
            cyc++;
        end
        cargar = 1'b0;
        check_eq({tag, " cycles to listo"}, cyc, 9);
        check_eq({tag, " ocupado cycles"}, busy, 9);
        check_eq({tag, " estado MUESTRA"}, estado, 4);
        check_eq({tag, " op_a held"}, op_a, a);
        check_eq({tag, " op_b held"}, op_b, b);
        check_result(r, tag);
    endtask

    task automatic run_op(input int a, input int b, input int sel, input bit disturb, input string tag);
        load_a_check(a, tag);
        run_b(a, b, sel, disturb, tag);
    endtask

    initial begin
        int listo_seen;
        repeat (3) @(negedge clk);
        check_eq("reset estado", estado, 0);
        check_eq("reset op_a", op_a, 0);
        check_eq("reset r_uni", bcd_r_uni, 0);
        check_eq("reset listo", listo, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(9, 7, 1, 1'b0, "9+7");

        // Back-to-back from MUESTRA: old result stays until the new one lands.
        load_a_check(4, "b2b");
        check_result(16, "b2b old");
        run_b(4, 2, 1, 1'b0, "b2b");

        // Reset after three shift cycles.
        load_a_check(9, "rstmid");
        pulse_load(4'd7, 4'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rstmid estado", estado, 0);
        check_eq("rstmid op_a", op_a, 0);
        check_eq("rstmid op_b", op_b, 0);
        check_eq("rstmid ocupado", ocupado, 0);
        check_eq("rstmid listo", listo, 0);
        check_eq("rstmid a_uni", bcd_a_uni, 0);
        check_eq("rstmid b_uni", bcd_b_uni, 0);
        check_result(0, "rstmid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(15, 15, 0, 1'b0, "15*15");
        forced_val = 8'd255;
        run_op(15, 15, 2, 1'b0, "f255");
        forced_val = 8'd0;
        run_op(15, 15, 2, 1'b0, "f0");
        run_op(5, 6, 1, 1'b1, "disturb");

        // cancelar beats cargar in ESPERA_B.
        load_a_check(8, "cancel");
        dato     = 4'd6;
        cargar   = 1'b1;
        cancelar = 1'b1;
        @(negedge clk);
        cargar   = 1'b0;
        cancelar = 1'b0;
        check_eq("cancel estado", estado, 0);
        check_eq("cancel op_a", op_a, 0);
        check_eq("cancel op_b", op_b, 0);

        // cancelar mid-conversion with a previous result on display.
        run_op(3, 4, 0, 1'b0, "3*4");
        load_a_check(2, "cancmid");
        pulse_load(4'd3, 4'd1);
        repeat (3) @(negedge clk);
        cancelar = 1'b1;
        @(negedge clk);
        cancelar = 1'b0;
        check_eq("cancmid estado", estado, 0);
        check_eq("cancmid a_uni", bcd_a_uni, 0);
        check_result(0, "cancmid");
        listo_seen = 0;
        repeat (15) begin
            if (listo || ocupado) listo_seen++;
            @(negedge clk);
        end
        check_eq("cancmid no listo", listo_seen, 0);

        for (int i = 0; i < 30; i++) begin
            int a, b, s;
            a = $urandom_range(15, 0);
            b = $urandom_range(15, 0);
            s = $urandom_range(3, 0);
            forced_val = 8'($urandom_range(255, 0));
            run_op(a, b, s, 1'($urandom_range(1, 0)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
